// File: rtl/lcd_ctrl_param.sv
// Parametrised LCD image controller: loads an IMG_W x IMG_H image from IROM, applies
// 2x2-window commands on a local buffer and streams the buffer out to IRAM on request.
module lcd_ctrl_param #(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    parameter int DW    = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [3:0]                     cmd,
    input  logic                           cmd_valid,
    input  logic [DW-1:0]                  IROM_Q,
    output logic                           IROM_rd,
    output logic [$clog2(IMG_W*IMG_H)-1:0] IROM_A,
    output logic                           IRAM_valid,
    output logic [DW-1:0]                  IRAM_D,
    output logic [$clog2(IMG_W*IMG_H)-1:0] IRAM_A,
    output logic                           busy,
    output logic                           done,
    output logic [1:0]                     state_o
);

    localparam int N  = IMG_W * IMG_H;
    localparam int AW = $clog2(N);
    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam int SW = DW + 2;

    localparam logic [AW-1:0] LAST   = AW'(N - 1);
    localparam logic [XW-1:0] X_HOME = XW'(IMG_W / 2 - 1);
    localparam logic [YW-1:0] Y_HOME = YW'(IMG_H / 2 - 1);
    localparam logic [XW-1:0] X_MAX  = XW'(IMG_W - 2);
    localparam logic [YW-1:0] Y_MAX  = YW'(IMG_H - 2);

    localparam logic [3:0] CMD_WR   = 4'h0;
    localparam logic [3:0] CMD_SU   = 4'h1;
    localparam logic [3:0] CMD_SD   = 4'h2;
    localparam logic [3:0] CMD_SL   = 4'h3;
    localparam logic [3:0] CMD_SR   = 4'h4;
    localparam logic [3:0] CMD_MAX  = 4'h5;
    localparam logic [3:0] CMD_MIN  = 4'h6;
    localparam logic [3:0] CMD_AVG  = 4'h7;
    localparam logic [3:0] CMD_CCR  = 4'h8;
    localparam logic [3:0] CMD_CR   = 4'h9;
    localparam logic [3:0] CMD_MX   = 4'hA;
    localparam logic [3:0] CMD_MY   = 4'hB;
    localparam logic [3:0] CMD_RLD  = 4'hC;
    localparam logic [3:0] CMD_HOME = 4'hD;

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_IDLE  = 2'd1,
        S_OP    = 2'd2,
        S_WRITE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic            rd_q;
    logic [AW-1:0]   a_q;
    logic            cap_q;
    logic [AW-1:0]   cap_a_q;
    logic [AW-1:0]   wa_q;
    logic            done_q;
    logic [3:0]      cmd_q;
    logic [XW-1:0]   x_q;
    logic [YW-1:0]   y_q;
    logic [DW-1:0]   img_q [N];

    logic [AW-1:0]   a0, a1, a2, a3;
    logic [DW-1:0]   p0, p1, p2, p3;
    logic [DW-1:0]   n0, n1, n2, n3;
    logic [DW-1:0]   mx, mn;
    logic [SW-1:0]   sum;
    logic            win_we;

    // Handshake: a command is taken on any rising edge where cmd_valid=1 and busy=0;
    // cmd_valid while busy=1 is dropped, never queued.
    always_comb begin
        state_d    = state_q;
        busy       = (state_q != S_IDLE);
        IRAM_valid = (state_q == S_WRITE);
        IRAM_A     = wa_q;
        IRAM_D     = '0;
        IROM_rd    = rd_q;
        IROM_A     = a_q;
        done       = done_q;
        state_o    = state_q;
        if (state_q == S_WRITE) begin
            IRAM_D = img_q[wa_q];
        end
        case (state_q)
            S_LOAD:  if (cap_q && cap_a_q == LAST) state_d = S_IDLE;
            S_IDLE:  if (cmd_valid) state_d = (cmd == CMD_WR) ? S_WRITE : S_OP;
            S_OP:    state_d = (cmd_q == CMD_RLD) ? S_LOAD : S_IDLE;
            S_WRITE: if (wa_q == LAST) state_d = S_IDLE;
            default: state_d = S_LOAD;
        endcase
    end

    always_comb begin
        a0     = {y_q, x_q};
        a1     = {y_q, x_q + XW'(1)};
        a2     = {y_q + YW'(1), x_q};
        a3     = {y_q + YW'(1), x_q + XW'(1)};
        p0     = img_q[a0];
        p1     = img_q[a1];
        p2     = img_q[a2];
        p3     = img_q[a3];
        sum    = SW'(p0) + SW'(p1) + SW'(p2) + SW'(p3);
        mx     = p0;
        if (p1 > mx) mx = p1;
        if (p2 > mx) mx = p2;
        if (p3 > mx) mx = p3;
        mn     = p0;
        if (p1 < mn) mn = p1;
        if (p2 < mn) mn = p2;
        if (p3 < mn) mn = p3;
        n0     = p0;
        n1     = p1;
        n2     = p2;
        n3     = p3;
        win_we = 1'b0;
        if (state_q == S_OP) begin
            case (cmd_q)
                CMD_MAX: begin n0 = mx; n1 = mx; n2 = mx; n3 = mx; win_we = 1'b1; end
                CMD_MIN: begin n0 = mn; n1 = mn; n2 = mn; n3 = mn; win_we = 1'b1; end
                CMD_AVG: begin
                    n0 = DW'(sum >> 2);
                    n1 = DW'(sum >> 2);
                    n2 = DW'(sum >> 2);
                    n3 = DW'(sum >> 2);
                    win_we = 1'b1;
                end
                CMD_CCR: begin n0 = p1; n1 = p3; n2 = p0; n3 = p2; win_we = 1'b1; end
                CMD_CR:  begin n0 = p2; n1 = p0; n2 = p3; n3 = p1; win_we = 1'b1; end
                CMD_MX:  begin n0 = p2; n1 = p3; n2 = p0; n3 = p1; win_we = 1'b1; end
                CMD_MY:  begin n0 = p1; n1 = p0; n2 = p3; n3 = p2; win_we = 1'b1; end
                default: win_we = 1'b0;
            endcase
        end
    end

    // rd_q=0 with cap_q=0 in LOAD means the fetch has not started yet (after reset).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_LOAD;
            rd_q    <= 1'b0;
            a_q     <= '0;
            cap_q   <= 1'b0;
            cap_a_q <= '0;
            wa_q    <= '0;
            done_q  <= 1'b0;
            cmd_q   <= '0;
            x_q     <= X_HOME;
            y_q     <= Y_HOME;
        end else begin
            state_q <= state_d;
            done_q  <= (state_q == S_WRITE) && (wa_q == LAST);
            case (state_q)
                S_LOAD: begin
                    cap_q   <= rd_q;
                    cap_a_q <= a_q;
                    if (rd_q) begin
                        if (a_q == LAST) rd_q <= 1'b0;
                        else             a_q  <= a_q + AW'(1);
                    end else if (!cap_q) begin
                        rd_q <= 1'b1;
                        a_q  <= '0;
                    end
                end
                S_IDLE: begin
                    if (cmd_valid) cmd_q <= cmd;
                end
                S_OP: begin
                    case (cmd_q)
                        CMD_SU:   if (y_q != '0)   y_q <= y_q - YW'(1);
                        CMD_SD:   if (y_q < Y_MAX) y_q <= y_q + YW'(1);
                        CMD_SL:   if (x_q != '0)   x_q <= x_q - XW'(1);
                        CMD_SR:   if (x_q < X_MAX) x_q <= x_q + XW'(1);
                        CMD_HOME: begin x_q <= X_HOME; y_q <= Y_HOME; end
                        CMD_RLD:  begin rd_q <= 1'b1; a_q <= '0; cap_q <= 1'b0; end
                        default:  ;
                    endcase
                end
                S_WRITE: begin
                    wa_q <= wa_q + AW'(1);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == S_LOAD && cap_q) begin
            img_q[cap_a_q] <= IROM_Q;
        end
        if (win_we) begin
            img_q[a0] <= n0;
            img_q[a1] <= n1;
            img_q[a2] <= n2;
            img_q[a3] <= n3;
        end
    end

endmodule

// File: tb/tb_lcd_ctrl_param.sv
// Bench for lcd_ctrl_param: ROM/RAM models around the DUT and an array-level image model.
module tb_lcd_ctrl_param;

  localparam int IMG_W = 8;
  localparam int IMG_H = 8;
  localparam int DW    = 8;
  localparam int N     = IMG_W * IMG_H;
  localparam int AW    = $clog2(N);

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    cmd;
  logic          cmd_valid;
  logic [DW-1:0] IROM_Q;
  logic          IROM_rd;
  logic [AW-1:0] IROM_A;
  logic          IRAM_valid;
  logic [DW-1:0] IRAM_D;
  logic [AW-1:0] IRAM_A;
  logic          busy;
  logic          done;
  logic [1:0]    state_o;

  lcd_ctrl_param #(.IMG_W(IMG_W), .IMG_H(IMG_H), .DW(DW)) dut (
    .clk(clk), .reset(reset), .cmd(cmd), .cmd_valid(cmd_valid), .IROM_Q(IROM_Q),
    .IROM_rd(IROM_rd), .IROM_A(IROM_A), .IRAM_valid(IRAM_valid), .IRAM_D(IRAM_D),
    .IRAM_A(IRAM_A), .busy(busy), .done(done), .state_o(state_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  logic [DW-1:0] rom [N];
  logic [DW-1:0] ram [N];
  always @(posedge clk) IROM_Q <= rom[IROM_A];

  int n_vec = 0;
  int n_err = 0;
  int done_seen = 0;
  int exp_done = 0;
  always @(negedge clk) if (done === 1'b1) done_seen++;

  // reference model: image as a flat array plus window origin
  int mimg [N];
  int ox, oy;
  logic [DW-1:0] exp_q [$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pix(int x, int y);
    return y * IMG_W + x;
  endfunction

  function automatic void model_home();
    ox = IMG_W / 2 - 1;
    oy = IMG_H / 2 - 1;
  endfunction

  function automatic void model_apply(int c);
    int idx [4];
    int p [4];
    int perm [4];
    int v;
    bit do_perm = 0;
    idx[0] = pix(ox, oy);
    idx[1] = pix(ox + 1, oy);
    idx[2] = pix(ox, oy + 1);
    idx[3] = pix(ox + 1, oy + 1);
    for (int i = 0; i < 4; i++) p[i] = mimg[idx[i]];
    perm = '{0, 1, 2, 3};
    case (c)
      1: if (oy > 0) oy--;
      2: if (oy < IMG_H - 2) oy++;
      3: if (ox > 0) ox--;
      4: if (ox < IMG_W - 2) ox++;
      5: begin
        v = p[0];
        for (int i = 1; i < 4; i++) if (p[i] > v) v = p[i];
        for (int i = 0; i < 4; i++) mimg[idx[i]] = v;
      end
      6: begin
        v = p[0];
        for (int i = 1; i < 4; i++) if (p[i] < v) v = p[i];
        for (int i = 0; i < 4; i++) mimg[idx[i]] = v;
      end
      7: begin
        v = (p[0] + p[1] + p[2] + p[3]) / 4;
        for (int i = 0; i < 4; i++) mimg[idx[i]] = v;
      end
      8:  begin perm = '{1, 3, 0, 2}; do_perm = 1; end
      9:  begin perm = '{2, 0, 3, 1}; do_perm = 1; end
      10: begin perm = '{2, 3, 0, 1}; do_perm = 1; end
      11: begin perm = '{1, 0, 3, 2}; do_perm = 1; end
      13: model_home();
      default: ;
    endcase
    if (do_perm) for (int i = 0; i < 4; i++) mimg[idx[i]] = p[perm[i]];
  endfunction

  // driver tasks
  task automatic wait_idle();
    int t = 0;
    while (busy !== 1'b0 && t < 4 * N) begin @(negedge clk); t++; end
    check_eq("idle_wait", busy, 0);
  endtask

  task automatic load_check();
    int t = 0;
    while (IROM_rd !== 1'b1 && t < 8) begin @(negedge clk); t++; end
    check_eq("load_rd_rise", IROM_rd, 1);
    for (int i = 0; i < N; i++) begin
      check_eq("load_addr", IROM_A, i);
      check_eq("load_busy", busy, 1);
      @(negedge clk);
    end
    check_eq("load_tail_busy", busy, 1);
    @(negedge clk);
    check_eq("load_ready", busy, 0);
    check_eq("load_rd_off", IROM_rd, 0);
    for (int i = 0; i < N; i++) mimg[i] = rom[i];
  endtask

  task automatic wr_check();
    for (int i = 0; i < N; i++) exp_q.push_back(DW'(mimg[i]));
    for (int i = 0; i < N; i++) begin
      check_eq("wr_valid", IRAM_valid, 1);
      check_eq("wr_addr", IRAM_A, i);
      check_eq("wr_data", IRAM_D, exp_q.pop_front());
      check_eq("wr_done_low", done, 0);
      ram[IRAM_A] = IRAM_D;
      @(negedge clk);
    end
    check_eq("wr_end_valid", IRAM_valid, 0);
    check_eq("wr_done_pulse", done, 1);
    check_eq("wr_end_busy", busy, 0);
    exp_done++;
  endtask

  task automatic send_cmd(input int c);
    wait_idle();
    check_eq("idle_rd", IROM_rd, 0);
    cmd = 4'(c);
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    check_eq("accept_busy", busy, 1);
    if (c == 0) begin
      wr_check();
    end else if (c == 12) begin
      load_check();
    end else begin
      model_apply(c);
      @(negedge clk);
      check_eq("op_turnaround", busy, 0);
    end
  endtask

  task automatic set_window(input int x, input int y, input int v0, input int v1,
                            input int v2, input int v3);
    rom[pix(x, y)]         = DW'(v0);
    rom[pix(x + 1, y)]     = DW'(v1);
    rom[pix(x, y + 1)]     = DW'(v2);
    rom[pix(x + 1, y + 1)] = DW'(v3);
  endtask

  int hx, hy, c;

  initial begin
    reset = 1'b0;
    cmd = '0;
    cmd_valid = 1'b0;
    for (int i = 0; i < N; i++) rom[i] = DW'(i);
    model_home();
    hx = IMG_W / 2 - 1;
    hy = IMG_H / 2 - 1;
    repeat (3) @(negedge clk);
    check_eq("rst_irom_rd", IROM_rd, 0);
    check_eq("rst_irom_a", IROM_A, 0);
    check_eq("rst_iram_valid", IRAM_valid, 0);
    check_eq("rst_iram_a", IRAM_A, 0);
    check_eq("rst_iram_d", IRAM_D, 0);
    check_eq("rst_busy", busy, 1);
    check_eq("rst_done", done, 0);
    reset = 1'b1;
    load_check();

    // identity image out
    send_cmd(0);
    check_eq("ident_0", ram[0], 0);
    check_eq("ident_mid", ram[N / 2], N / 2);
    check_eq("ident_last", ram[N - 1], N - 1);

    // clamp at origin (0,0) then MAX
    repeat (4) send_cmd(3);
    repeat (4) send_cmd(1);
    send_cmd(5);
    send_cmd(0);
    check_eq("max_p0", ram[0], IMG_W + 1);
    check_eq("max_p1", ram[1], IMG_W + 1);
    check_eq("max_p2", ram[IMG_W], IMG_W + 1);
    check_eq("max_p3", ram[IMG_W + 1], IMG_W + 1);
    check_eq("max_outside", ram[2], 2);

    // AVG at home window
    send_cmd(13);
    set_window(hx, hy, 10, 20, 30, 41);
    send_cmd(12);
    send_cmd(7);
    send_cmd(0);
    check_eq("avg_p0", ram[pix(hx, hy)], 25);
    check_eq("avg_p3", ram[pix(hx + 1, hy + 1)], 25);

    // CCR, then CR+CCR restores
    set_window(hx, hy, 1, 2, 3, 4);
    send_cmd(12);
    send_cmd(8);
    send_cmd(0);
    check_eq("ccr_p0", ram[pix(hx, hy)], 2);
    check_eq("ccr_p1", ram[pix(hx + 1, hy)], 4);
    check_eq("ccr_p2", ram[pix(hx, hy + 1)], 1);
    check_eq("ccr_p3", ram[pix(hx + 1, hy + 1)], 3);
    send_cmd(9);
    send_cmd(8);
    send_cmd(0);
    check_eq("crccr_p0", ram[pix(hx, hy)], 2);
    check_eq("crccr_p1", ram[pix(hx + 1, hy)], 4);

    // WR, MY, WR
    send_cmd(0);
    send_cmd(11);
    send_cmd(0);

    // cmd_valid held high: accepted every second cycle
    wait_idle();
    cmd = 4'd2;
    cmd_valid = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 5) cmd_valid = 1'b0;
      check_eq("hold_busy", busy, k % 2);
    end
    repeat (3) model_apply(2);
    send_cmd(5);
    send_cmd(0);

    // reset in the middle of a write
    wait_idle();
    cmd = 4'd0;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (9) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check_eq("midrst_valid", IRAM_valid, 0);
    check_eq("midrst_busy", busy, 1);
    check_eq("midrst_done", done, 0);
    check_eq("midrst_iram_a", IRAM_A, 0);
    @(negedge clk);
    reset = 1'b1;
    model_home();
    load_check();
    send_cmd(0);

    // randomized command stream
    for (int i = 0; i < N; i++) rom[i] = DW'($urandom);
    send_cmd(12);
    for (int k = 0; k < 80; k++) begin
      c = int'($urandom_range(0, 99));
      if (c < 8) begin
        c = 0;
      end else if (c < 12) begin
        for (int j = 0; j < 4; j++) rom[$urandom_range(0, N - 1)] = DW'($urandom);
        c = 12;
      end else begin
        c = int'($urandom_range(1, 15));
      end
      send_cmd(c);
    end
    send_cmd(0);

    @(negedge clk);
    check_eq("done_count", done_seen, exp_done);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
